// File: rtl/spi_seq_loader_pkg.sv
// Shared state encoding and SPI core register map for spi_seq_loader.
package spi_seq_loader_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StCfgLo,
    StCfgHi,
    StLoad,
    StStart,
    StGap,
    StPoll,
    StPollChk,
    StRd,
    StRdCap,
    StRdOut
  } state_e;

  localparam int unsigned REG_START    = 1;
  localparam int unsigned REG_BITS_LO  = 3;
  localparam int unsigned REG_BITS_HI  = 4;
  localparam int unsigned MEM_OUT_BASE = 16;

  // The core places its capture memory directly after its output memory.
  function automatic int unsigned in_mem_base(input int unsigned mem_bytes);
    return MEM_OUT_BASE + mem_bytes;
  endfunction

endpackage

// File: rtl/spi_seq_loader_gap_timer.sv
// DONE-poll spacing countdown plus optional poll timeout (SPI_SEQ_LOADER_TIMEOUT_EN).
module spi_seq_loader_gap_timer #(
  parameter int unsigned POLL_GAP    = 8,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic BUS_CLK,
  input  logic BUS_RST_N,
  input  logic gap_load,
  input  logic gap_run,
  input  logic to_clear,
  input  logic to_run,
  output logic gap_expire,
  output logic to_expire
);

  logic [7:0] gap_cnt_q;

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      gap_cnt_q <= '0;
    end else if (gap_load) begin
      gap_cnt_q <= 8'(POLL_GAP);
    end else if (gap_run && (gap_cnt_q != 8'd0)) begin
      gap_cnt_q <= gap_cnt_q - 8'd1;
    end
  end

  // Fires on the cycle the count reaches zero, giving POLL_GAP idle cycles.
  assign gap_expire = gap_run && (gap_cnt_q <= 8'd1);

`ifdef SPI_SEQ_LOADER_TIMEOUT_EN
  logic [31:0] to_cnt_q;

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      to_cnt_q <= '0;
    end else if (to_clear) begin
      to_cnt_q <= '0;
    end else if (to_run) begin
      to_cnt_q <= to_cnt_q + 32'd1;
    end
  end

  assign to_expire = to_run && (to_cnt_q == (32'(TIMEOUT_CYC) - 32'd1));
`else
  logic unused_to;
  assign unused_to = to_clear ^ to_run;
  assign to_expire = 1'b0;
`endif

endmodule

// File: rtl/spi_seq_loader.sv
// Bus master that loads, starts, polls and reads back the SPI core.
// Optional poll timeout enabled by defining SPI_SEQ_LOADER_TIMEOUT_EN.
module spi_seq_loader
  import spi_seq_loader_pkg::*;
#(
  parameter int unsigned ABUSWIDTH   = 16,
  parameter int unsigned MEM_BYTES   = 16,
  parameter int unsigned POLL_GAP    = 8,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST_N,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  input  logic [15:0]          CMD_NBITS,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [7:0]           IN_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [7:0]           OUT_DATA,
  output logic [ABUSWIDTH-1:0] M_ADD,
  output logic [7:0]           M_DATA_OUT,
  input  logic [7:0]           M_DATA_IN,
  output logic                 M_RD,
  output logic                 M_WR,
  output logic                 BUSY,
  output logic                 ERR
);

  localparam int unsigned CW      = $clog2(MEM_BYTES) + 1;
  localparam int unsigned IN_BASE = in_mem_base(MEM_BYTES);

  state_e          state_q;
  logic [15:0]     nbits_q;
  logic [CW-1:0]   nbytes_q;
  logic [CW-1:0]   k_q;
  logic [7:0]      out_data_q;
  logic            err_q;

  logic [16:0]     nbytes_w;
  logic            cmd_bad;
  logic            last_byte;
  logic            gap_load, gap_run, to_clear, to_run;
  logic            gap_expire, to_expire;

  assign nbytes_w  = ({1'b0, CMD_NBITS} + 17'd7) >> 3;
  assign cmd_bad   = (CMD_NBITS == 16'd0) || (nbytes_w > 17'(MEM_BYTES));
  assign last_byte = (k_q == (nbytes_q - CW'(1)));

  assign gap_load = (state_q == StStart) || ((state_q == StPollChk) && !M_DATA_IN[0]);
  assign gap_run  = (state_q == StGap);
  assign to_clear = (state_q == StStart);
  assign to_run   = (state_q == StGap) || (state_q == StPoll) || (state_q == StPollChk);

  spi_seq_loader_gap_timer #(
    .POLL_GAP    (POLL_GAP),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_gap_timer (
    .BUS_CLK    (BUS_CLK),
    .BUS_RST_N  (BUS_RST_N),
    .gap_load   (gap_load),
    .gap_run    (gap_run),
    .to_clear   (to_clear),
    .to_run     (to_run),
    .gap_expire (gap_expire),
    .to_expire  (to_expire)
  );

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_q    <= StIdle;
      nbits_q    <= '0;
      nbytes_q   <= '0;
      k_q        <= '0;
      out_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (CMD_VALID) begin
            if (cmd_bad) begin
              err_q <= 1'b1;
            end else begin
              nbits_q  <= CMD_NBITS;
              nbytes_q <= nbytes_w[CW-1:0];
              k_q      <= '0;
              state_q  <= StCfgLo;
            end
          end
        end
        StCfgLo: state_q <= StCfgHi;
        StCfgHi: state_q <= StLoad;
        StLoad: begin
          if (IN_VALID) begin
            if (last_byte) begin
              k_q     <= '0;
              state_q <= StStart;
            end else begin
              k_q <= k_q + CW'(1);
            end
          end
        end
        StStart: state_q <= StGap;
        StGap: begin
          if (to_expire) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else if (gap_expire) begin
            state_q <= StPoll;
          end
        end
        StPoll: begin
          if (to_expire) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else begin
            state_q <= StPollChk;
          end
        end
        StPollChk: begin
          if (to_expire) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else if (M_DATA_IN[0]) begin
            state_q <= StRd;
          end else begin
            state_q <= StGap;
          end
        end
        StRd: state_q <= StRdCap;
        StRdCap: begin
          out_data_q <= M_DATA_IN;
          state_q    <= StRdOut;
        end
        StRdOut: begin
          if (OUT_READY) begin
            if (last_byte) begin
              k_q     <= '0;
              state_q <= StIdle;
            end else begin
              k_q     <= k_q + CW'(1);
              state_q <= StRd;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Bus strobes decode from state; LOAD writes in the same cycle as the IN handshake.
  always_comb begin
    M_WR       = 1'b0;
    M_RD       = 1'b0;
    M_ADD      = '0;
    M_DATA_OUT = '0;
    unique case (state_q)
      StCfgLo: begin
        M_WR       = 1'b1;
        M_ADD      = ABUSWIDTH'(REG_BITS_LO);
        M_DATA_OUT = nbits_q[7:0];
      end
      StCfgHi: begin
        M_WR       = 1'b1;
        M_ADD      = ABUSWIDTH'(REG_BITS_HI);
        M_DATA_OUT = nbits_q[15:8];
      end
      StLoad: begin
        M_WR       = IN_VALID;
        M_ADD      = ABUSWIDTH'(MEM_OUT_BASE) + ABUSWIDTH'(k_q);
        M_DATA_OUT = IN_VALID ? IN_DATA : 8'd0;
      end
      StStart: begin
        M_WR  = 1'b1;
        M_ADD = ABUSWIDTH'(REG_START);
      end
      StPoll: begin
        M_RD  = 1'b1;
        M_ADD = ABUSWIDTH'(REG_START);
      end
      StRd: begin
        M_RD  = 1'b1;
        M_ADD = ABUSWIDTH'(IN_BASE) + ABUSWIDTH'(k_q);
      end
      default: ;
    endcase
  end

  assign CMD_READY = (state_q == StIdle);
  assign BUSY      = (state_q != StIdle);
  assign IN_READY  = (state_q == StLoad);
  assign OUT_VALID = (state_q == StRdOut);
  assign OUT_DATA  = out_data_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_spi_seq_loader.sv
// Randomized bench for spi_seq_loader against a loopback SPI core model.
module tb_spi_seq_loader;

  localparam int unsigned MEM_BYTES = 16;
  localparam int unsigned POLL_GAP  = 8;
`ifdef SPI_SEQ_LOADER_TIMEOUT_EN
  localparam int unsigned TIMEOUT_CYC = 100;
`else
  localparam int unsigned TIMEOUT_CYC = 65535;
`endif
  localparam int unsigned IN_BASE = 16 + MEM_BYTES;

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST_N = 1'b0;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [15:0] CMD_NBITS = '0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [7:0]  IN_DATA = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [7:0]  OUT_DATA;
  logic [15:0] M_ADD;
  logic [7:0]  M_DATA_OUT;
  logic [7:0]  M_DATA_IN = '0;
  logic        M_RD, M_WR, BUSY, ERR;

  always #5 BUS_CLK = ~BUS_CLK;

  spi_seq_loader #(
    .ABUSWIDTH   (16),
    .MEM_BYTES   (MEM_BYTES),
    .POLL_GAP    (POLL_GAP),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .BUS_CLK    (BUS_CLK),
    .BUS_RST_N  (BUS_RST_N),
    .CMD_VALID  (CMD_VALID),
    .CMD_READY  (CMD_READY),
    .CMD_NBITS  (CMD_NBITS),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .IN_DATA    (IN_DATA),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_DATA   (OUT_DATA),
    .M_ADD      (M_ADD),
    .M_DATA_OUT (M_DATA_OUT),
    .M_DATA_IN  (M_DATA_IN),
    .M_RD       (M_RD),
    .M_WR       (M_WR),
    .BUSY       (BUSY),
    .ERR        (ERR)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Loopback core model: START copies output memory into input memory after a delay.
  logic [7:0]  core_mem [256];
  logic        core_done = 1'b0;
  int          core_timer = 0;
  int          core_delay = 20;
  bit          core_never_done = 1'b0;
  int          cyc = 0;
  int          last_start_cyc = 0;
  int          last_poll_ref = -1000;
  int          viol = 0;
  int          rd_cnt = 0;
  int          rd_mem_cnt = 0;
  logic [23:0] wr_log [$];
  bit          ov_hold = 1'b0;
  logic [7:0]  ov_data = '0;

  initial for (int i = 0; i < 256; i++) core_mem[i] = 8'h00;

  always @(posedge BUS_CLK) begin
    cyc++;
    if (M_RD && M_WR) viol++;
    if (OUT_VALID && M_RD) viol++;
    if (ov_hold && (!OUT_VALID || OUT_DATA !== ov_data)) viol++;
    ov_hold = OUT_VALID && !OUT_READY && BUS_RST_N;
    ov_data = OUT_DATA;
    if (M_RD) begin
      rd_cnt++;
      if (M_ADD == 16'd1) begin
        if (cyc - last_poll_ref < int'(POLL_GAP)) viol++;
        last_poll_ref = cyc;
        M_DATA_IN <= {7'd0, core_done};
      end else begin
        if (int'(M_ADD) >= int'(IN_BASE)) rd_mem_cnt++;
        M_DATA_IN <= core_mem[M_ADD[7:0]];
      end
    end
    if (M_WR) begin
      wr_log.push_back({M_ADD, M_DATA_OUT});
      if (M_ADD == 16'd0) viol++;
      core_mem[M_ADD[7:0]] = M_DATA_OUT;
      if (M_ADD == 16'd1) begin
        core_done      = 1'b0;
        core_timer     = core_delay;
        last_poll_ref  = cyc;
        last_start_cyc = cyc;
      end
    end else if (core_timer > 0) begin
      core_timer--;
      if (core_timer == 0 && !core_never_done) begin
        for (int k = 0; k < int'(MEM_BYTES); k++) core_mem[IN_BASE + k] = core_mem[16 + k];
        core_done = 1'b1;
      end
    end
  end

  logic [7:0]  in_bytes [$];
  logic [7:0]  out_got [$];
  logic [23:0] exp_wr [$];
  int          first_stall = 0;
  logic [7:0]  stall_d0 = '0;
  logic [7:0]  stall_d1 = '0;
  int          stall_rd = 0;

  // Reference transaction: cfg lo/hi, one write per byte in order, then START.
  function automatic void model_writes(input logic [15:0] nbits);
    int nb;
    nb = (int'(nbits) + 7) / 8;
    exp_wr.delete();
    exp_wr.push_back({16'd3, nbits[7:0]});
    exp_wr.push_back({16'd4, nbits[15:8]});
    for (int k = 0; k < nb; k++) exp_wr.push_back({16'(16 + k), in_bytes[k]});
    exp_wr.push_back({16'd1, 8'h00});
  endfunction

  task automatic run_cmd(input logic [15:0] nbits, input int stall_max, output bit ok);
    int nb, idx, guard, stall, rd0;
    bit first;
    nb = (int'(nbits) + 7) / 8;
    idx = 0; guard = 0; first = 1'b1; rd0 = 0;
    out_got.delete();
    wr_log.delete();
    while (!CMD_READY && guard < 100) begin @(negedge BUS_CLK); guard++; end
    CMD_VALID = 1'b1;
    CMD_NBITS = nbits;
    @(negedge BUS_CLK);
    CMD_VALID = 1'b0;
    stall = first_stall;
    guard = 0;
    while (out_got.size() < nb && guard < 5000) begin
      if (IN_READY && idx < nb && $urandom_range(0, 3) != 0) begin
        IN_VALID = 1'b1;
        IN_DATA  = in_bytes[idx];
        idx++;
      end else begin
        IN_VALID = 1'b0;
        IN_DATA  = 8'($urandom);
      end
      OUT_READY = 1'b0;
      if (OUT_VALID) begin
        if (first && stall == first_stall) begin
          stall_d0 = OUT_DATA;
          rd0      = rd_cnt;
        end
        if (stall > 0) begin
          stall--;
        end else begin
          OUT_READY = 1'b1;
          out_got.push_back(OUT_DATA);
          if (first) begin
            stall_d1 = OUT_DATA;
            stall_rd = rd_cnt - rd0;
            first    = 1'b0;
          end
          stall = $urandom_range(0, stall_max);
        end
      end
      @(negedge BUS_CLK);
      guard++;
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    @(negedge BUS_CLK);
    ok = (guard < 5000);
  endtask

  task automatic test_reset;
    BUS_RST_N = 1'b0;
    repeat (3) @(negedge BUS_CLK);
    n_tests++;
    if ({CMD_READY, IN_READY, OUT_VALID, M_RD, M_WR, BUSY, ERR} !== 7'b1000000) begin
      $display("FAIL reset_ctrl: got %b expected 1000000",
               {CMD_READY, IN_READY, OUT_VALID, M_RD, M_WR, BUSY, ERR});
      n_fail++;
    end
    n_tests++;
    if (M_ADD !== 16'd0 || M_DATA_OUT !== 8'd0 || OUT_DATA !== 8'd0) begin
      $display("FAIL reset_data: got add=%h wd=%h od=%h expected 0", M_ADD, M_DATA_OUT, OUT_DATA);
      n_fail++;
    end
    BUS_RST_N = 1'b1;
    repeat (2) @(negedge BUS_CLK);
    n_tests++;
    if (CMD_READY !== 1'b1 || BUSY !== 1'b0) begin
      $display("FAIL reset_release: got ready=%b busy=%b expected 1/0", CMD_READY, BUSY);
      n_fail++;
    end
  endtask

  task automatic test_basic;
    bit ok;
    in_bytes = '{8'hA5, 8'h3C};
    core_delay = 30;
    run_cmd(16'd16, 2, ok);
    model_writes(16'd16);
    n_tests++;
    if (!ok) begin $display("FAIL basic_timeout: got stuck expected completion"); n_fail++; end
    n_tests++;
    if (wr_log.size() != exp_wr.size()) begin
      $display("FAIL basic_nwr: got %0d expected %0d", wr_log.size(), exp_wr.size());
      n_fail++;
    end
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++) begin
      n_tests++;
      if (wr_log[i] !== exp_wr[i]) begin
        $display("FAIL basic_wr[%0d]: got %h expected %h", i, wr_log[i], exp_wr[i]);
        n_fail++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (i >= out_got.size() || out_got[i] !== in_bytes[i]) begin
        $display("FAIL basic_out[%0d]: got %h expected %h", i,
                 (i < out_got.size()) ? out_got[i] : 8'hxx, in_bytes[i]);
        n_fail++;
      end
    end
    n_tests++;
    if (BUSY !== 1'b0 || CMD_READY !== 1'b1) begin
      $display("FAIL basic_idle: got busy=%b ready=%b expected 0/1", BUSY, CMD_READY);
      n_fail++;
    end
  endtask

  task automatic test_partial_byte;
    bit ok;
    in_bytes = '{8'h9E, 8'h70};
    core_delay = 5;
    run_cmd(16'd12, 0, ok);
    n_tests++;
    if (!ok || wr_log.size() < 2) begin
      $display("FAIL partial_run: got ok=%b nwr=%0d expected 1/>=2", ok, wr_log.size());
      n_fail++;
    end else begin
      n_tests++;
      if (wr_log[0] !== {16'd3, 8'h0C} || wr_log[1] !== {16'd4, 8'h00}) begin
        $display("FAIL partial_cfg: got %h %h expected 00030c 000400", wr_log[0], wr_log[1]);
        n_fail++;
      end
    end
    n_tests++;
    if (out_got.size() != 2 || out_got[0] !== 8'h9E || out_got[1] !== 8'h70) begin
      $display("FAIL partial_out: got n=%0d expected 2 bytes 9e 70", out_got.size());
      n_fail++;
    end
  endtask

  task automatic test_reject;
    logic [15:0] bad [2];
    int rd0;
    bad[0] = 16'd0;
    bad[1] = 16'(8 * MEM_BYTES + 1);
    for (int i = 0; i < 2; i++) begin
      rd0 = rd_cnt;
      wr_log.delete();
      CMD_VALID = 1'b1;
      CMD_NBITS = bad[i];
      @(negedge BUS_CLK);
      CMD_VALID = 1'b0;
      n_tests++;
      if (ERR !== 1'b1 || BUSY !== 1'b0) begin
        $display("FAIL reject_err[%0d]: got err=%b busy=%b expected 1/0", i, ERR, BUSY);
        n_fail++;
      end
      @(negedge BUS_CLK);
      n_tests++;
      if (ERR !== 1'b0 || BUSY !== 1'b0 || CMD_READY !== 1'b1) begin
        $display("FAIL reject_pulse[%0d]: got err=%b busy=%b ready=%b expected 0/0/1",
                 i, ERR, BUSY, CMD_READY);
        n_fail++;
      end
      repeat (4) @(negedge BUS_CLK);
      n_tests++;
      if (wr_log.size() != 0 || rd_cnt != rd0 || BUSY !== 1'b0) begin
        $display("FAIL reject_bus[%0d]: got nwr=%0d nrd=%0d busy=%b expected 0/0/0",
                 i, wr_log.size(), rd_cnt - rd0, BUSY);
        n_fail++;
      end
    end
  endtask

  task automatic test_random;
    bit ok;
    int nb;
    logic [15:0] nbits;
    for (int t = 0; t < 6; t++) begin
      nbits = 16'($urandom_range(1, 8 * MEM_BYTES));
      nb = (int'(nbits) + 7) / 8;
      in_bytes.delete();
      for (int k = 0; k < nb; k++) in_bytes.push_back(8'($urandom));
      core_delay = $urandom_range(2, 60);
      run_cmd(nbits, 4, ok);
      model_writes(nbits);
      n_tests++;
      if (!ok || wr_log.size() != exp_wr.size() || out_got.size() != nb) begin
        $display("FAIL rand%0d_shape: got ok=%b nwr=%0d nout=%0d expected 1/%0d/%0d",
                 t, ok, wr_log.size(), out_got.size(), exp_wr.size(), nb);
        n_fail++;
      end
      for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++) begin
        n_tests++;
        if (wr_log[i] !== exp_wr[i]) begin
          $display("FAIL rand%0d_wr[%0d]: got %h expected %h", t, i, wr_log[i], exp_wr[i]);
          n_fail++;
        end
      end
      for (int i = 0; i < nb && i < out_got.size(); i++) begin
        n_tests++;
        if (out_got[i] !== in_bytes[i]) begin
          $display("FAIL rand%0d_out[%0d]: got %h expected %h", t, i, out_got[i], in_bytes[i]);
          n_fail++;
        end
      end
    end
  endtask

  task automatic test_out_stall;
    bit ok;
    in_bytes = '{8'hC7, 8'h18, 8'h5D};
    core_delay = 12;
    first_stall = 20;
    run_cmd(16'd24, 0, ok);
    first_stall = 0;
    n_tests++;
    if (!ok || stall_d0 !== 8'hC7 || stall_d1 !== 8'hC7) begin
      $display("FAIL stall_data: got ok=%b start=%h end=%h expected 1/c7/c7", ok, stall_d0, stall_d1);
      n_fail++;
    end
    n_tests++;
    if (stall_rd != 0) begin
      $display("FAIL stall_rd: got %0d reads expected 0", stall_rd);
      n_fail++;
    end
    n_tests++;
    if (out_got.size() != 3 || out_got[2] !== 8'h5D) begin
      $display("FAIL stall_out: got n=%0d expected 3 ending 5d", out_got.size());
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_load;
    bit ok;
    int guard;
    guard = 0;
    CMD_VALID = 1'b1;
    CMD_NBITS = 16'd24;
    @(negedge BUS_CLK);
    CMD_VALID = 1'b0;
    while (!IN_READY && guard < 20) begin @(negedge BUS_CLK); guard++; end
    IN_VALID = 1'b1;
    IN_DATA  = 8'h11;
    @(negedge BUS_CLK);
    IN_DATA   = 8'h22;
    BUS_RST_N = 1'b0;
    #1;
    n_tests++;
    if ({CMD_READY, IN_READY, OUT_VALID, M_RD, M_WR, BUSY, ERR} !== 7'b1000000 ||
        M_ADD !== 16'd0 || M_DATA_OUT !== 8'd0 || OUT_DATA !== 8'd0) begin
      $display("FAIL midreset_out: got ctl=%b add=%h wd=%h od=%h expected 1000000/0/0/0",
               {CMD_READY, IN_READY, OUT_VALID, M_RD, M_WR, BUSY, ERR}, M_ADD, M_DATA_OUT, OUT_DATA);
      n_fail++;
    end
    IN_VALID = 1'b0;
    @(negedge BUS_CLK);
    BUS_RST_N = 1'b1;
    @(negedge BUS_CLK);
    in_bytes = '{8'h5A, 8'hC3};
    core_delay = 25;
    run_cmd(16'd16, 1, ok);
    model_writes(16'd16);
    n_tests++;
    if (!ok || wr_log.size() != exp_wr.size() || out_got.size() != 2 ||
        out_got[0] !== 8'h5A || out_got[1] !== 8'hC3) begin
      $display("FAIL midreset_next: got ok=%b nwr=%0d nout=%0d expected 1/%0d/2 (5a c3)",
               ok, wr_log.size(), out_got.size(), exp_wr.size());
      n_fail++;
    end
  endtask

`ifdef SPI_SEQ_LOADER_TIMEOUT_EN
  task automatic test_timeout;
    int guard, rdm0, span;
    guard = 0;
    rdm0 = rd_mem_cnt;
    core_never_done = 1'b1;
    CMD_VALID = 1'b1;
    CMD_NBITS = 16'd8;
    @(negedge BUS_CLK);
    CMD_VALID = 1'b0;
    while (!IN_READY && guard < 20) begin @(negedge BUS_CLK); guard++; end
    IN_VALID = 1'b1;
    IN_DATA  = 8'h77;
    @(negedge BUS_CLK);
    IN_VALID = 1'b0;
    guard = 0;
    while (!ERR && guard < 1000) begin @(negedge BUS_CLK); guard++; end
    span = cyc - last_start_cyc;
    n_tests++;
    if (ERR !== 1'b1 || span != int'(TIMEOUT_CYC)) begin
      $display("FAIL timeout_err: got err=%b span=%0d expected 1/%0d", ERR, span, TIMEOUT_CYC);
      n_fail++;
    end
    n_tests++;
    if (CMD_READY !== 1'b1 || BUSY !== 1'b0 || rd_mem_cnt != rdm0) begin
      $display("FAIL timeout_idle: got ready=%b busy=%b memrd=%0d expected 1/0/0",
               CMD_READY, BUSY, rd_mem_cnt - rdm0);
      n_fail++;
    end
    core_never_done = 1'b0;
    @(negedge BUS_CLK);
  endtask
`endif

  task automatic test_protocol;
    n_tests++;
    if (viol != 0) begin
      $display("FAIL protocol: got %0d bus/handshake violations expected 0", viol);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial_byte();
    test_reject();
    test_random();
    test_out_stall();
    test_reset_mid_load();
`ifdef SPI_SEQ_LOADER_TIMEOUT_EN
    test_timeout();
`endif
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_seq_loader.md
Name: spi_seq_loader

Overview:
- Single-clock bus master that sits directly upstream of the SPI core and drives its 8-bit register/memory bus.
- Accepts a command (bit count) plus a byte stream, and writes the bytes into the core's output memory.
- Programs the bit count, issues START, then polls DONE.
- Reads the captured input memory back and returns it as a byte stream, so software or a sequencer never touches the core's registers directly.

Parameters:
- ABUSWIDTH, 16, width of M_ADD.
- MEM_BYTES, 16, SPI core memory depth in bytes; must match the core instance.
- POLL_GAP, 8, idle cycles between DONE polls; legal range 2..255.
- TIMEOUT_CYC, 65535, poll cycles before abort; used only with the optional feature.

Ports:
- BUS_CLK  in  1  clock, shared with the SPI core bus side.
- BUS_RST_N  in  1  asynchronous, active-low reset.
- CMD_VALID  in  1  command valid.
- CMD_READY  out  1  command accepted when VALID&READY.
- CMD_NBITS  in  16  bits to shift.
- IN_VALID  in  1  write-byte valid.
- IN_READY  out  1  write-byte ready.
- IN_DATA  in  8  byte to shift out; the first byte goes first, MSB first.
- OUT_VALID  out  1  readback byte valid.
- OUT_READY  in  1  readback byte ready.
- OUT_DATA  out  8  captured byte, same ordering as IN_DATA.
- M_ADD  out  ABUSWIDTH  core bus address.
- M_DATA_OUT  out  8  core bus write data.
- M_DATA_IN  in  8  core bus read data; valid the cycle after M_RD.
- M_RD  out  1  core bus read strobe.
- M_WR  out  1  core bus write strobe.
- BUSY  out  1  high whenever state is not IDLE.
- ERR  out  1  one-cycle pulse on rejected or aborted command.

Behaviour:
- Reset (async assert, sync release) values:
  - State IDLE.
  - CMD_READY=1; IN_READY, OUT_VALID, M_RD, M_WR, BUSY, ERR = 0.
  - M_ADD, M_DATA_OUT, OUT_DATA = 0.
- NBYTES = ceil(CMD_NBITS/8), computed in 17-bit arithmetic. Byte counter is $clog2(MEM_BYTES)+1 bits wide.
- Command accept in IDLE with CMD_VALID=1:
  - CMD_NBITS==0 or NBYTES>MEM_BYTES: ERR pulses the next cycle, state stays IDLE, command consumed, no bus activity.
  - Otherwise latch NBITS and go to CFG_LO.
- Core bus rules:
  - At most one of M_RD/M_WR high per cycle; each is a single-cycle strobe.
  - Address 0 is never written, because a write there soft-resets the core.
- States:
  - CFG_LO: write addr 3 = NBITS[7:0]. Next CFG_HI.
  - CFG_HI: write addr 4 = NBITS[15:8]. Next LOAD.
  - LOAD: IN_READY=1. Each IN handshake writes addr 16+k = IN_DATA in the same cycle, k=0..NBYTES-1. After the last byte go to START.
  - START: write addr 1, data 0. Load the gap counter with POLL_GAP. Next GAP.
  - GAP: count down; at 0 go to POLL.
  - POLL: M_RD at addr 1. Next POLL_CHK.
  - POLL_CHK: sample M_DATA_IN[0]. If 1 go to RD; if 0 reload the gap counter and go to GAP.
  - The first poll never occurs earlier than POLL_GAP cycles after START, so the core's DONE flag has cleared.
  - RD: M_RD at addr 16+MEM_BYTES+k. Next RD_CAP.
  - RD_CAP: latch M_DATA_IN into OUT_DATA, set OUT_VALID. Next RD_OUT.
  - RD_OUT: hold OUT_DATA/OUT_VALID until OUT_READY. Then k++ and go to RD, or to IDLE after NBYTES bytes.
- CMD_READY=1 only in IDLE. A new command can be accepted the cycle after the final OUT handshake.
- Trailing bits of a partial last byte: the loader passes them through unmodified.
- Stalls:
  - IN_VALID low in LOAD stalls indefinitely.
  - OUT_READY low stalls indefinitely; OUT_DATA stays stable while stalled.
- Reset asserted mid-operation: immediate return to reset values. The core's transfer is not aborted.

Optional Feature:
- Macro SPI_SEQ_LOADER_TIMEOUT_EN.
- Defined: a 32-bit counter starts in START and increments every cycle in GAP/POLL/POLL_CHK. When it reaches TIMEOUT_CYC: ERR pulses, state goes to IDLE, and no readback occurs.
- Undefined: no counter; polling continues forever.

Decomposition:
- Package spi_seq_loader_pkg holds:
  - State enum.
  - Core register offsets: REG_START=1, REG_BITS_LO=3, REG_BITS_HI=4, MEM_OUT_BASE=16.
  - A function giving the input-memory base from MEM_BYTES.
- One natural sub-module: spi_seq_loader_gap_timer, which owns the POLL_GAP countdown and the optional timeout counter and produces expire pulses.

Test Plan:
- NBITS=16, bytes A5,3C -> writes (3,10),(4,00),(16,A5),(17,3C),(1,00); polls at ≥8-cycle spacing; with a loopback core, OUT = A5,3C.
- NBITS=12 -> NBYTES=2; addr 4 written 00, addr 3 written 0C; two OUT bytes.
- NBITS=0 and NBITS=8*MEM_BYTES+1 -> ERR one cycle each; zero M_WR/M_RD; BUSY stays 0.
- OUT_READY held low 20 cycles on byte 0 -> OUT_DATA stable; no further M_RD until the handshake.
- BUS_RST_N pulsed low during LOAD -> all outputs at reset values the same cycle; next command runs cleanly.
- With SPI_SEQ_LOADER_TIMEOUT_EN, TIMEOUT_CYC=100, DONE never set -> ERR after 100 poll cycles; IDLE; no readback.
